// File: rtl/hp_pkg.sv
// Shared constants and types for the battle HP drain controller and its bar scheduler.
package hp_pkg;

    localparam int HP_W  = 8;
    localparam int BAR_W = 6;

    localparam logic [HP_W-1:0] HP_MAX = 8'd83;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    typedef enum logic {
        TGT_PLAYER = 1'b0,
        TGT_ENEMY  = 1'b1
    } target_t;

endpackage

// File: rtl/hp_bar_scheduler.sv
// Time-shares the single registered HP-to-bar lookup between the player and enemy bars,
// alternating every cycle and latching each result into the bar it was issued for.
module hp_bar_scheduler
    import hp_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [HP_W-1:0]  player_hp,
    input  logic [HP_W-1:0]  enemy_hp,
    output logic [HP_W-1:0]  lookup_hp,
    input  logic [BAR_W-1:0] lookup_bar,
    output logic [BAR_W-1:0] player_bar,
    output logic [BAR_W-1:0] enemy_bar
);

    logic ptr;
    logic ptr_q;
    logic vld_q;

    assign lookup_hp = ptr ? enemy_hp : player_hp;

    // vld_q masks the first cycle after reset, when the lookup holds no issued result yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= 1'b0;
            ptr_q      <= 1'b0;
            vld_q      <= 1'b0;
            player_bar <= '0;
            enemy_bar  <= '0;
        end else begin
            ptr   <= ~ptr;
            ptr_q <= ptr;
            vld_q <= 1'b1;
            if (vld_q) begin
                if (ptr_q) enemy_bar  <= lookup_bar;
                else       player_bar <= lookup_bar;
            end
        end
    end

endmodule

// File: rtl/hp_drain_ctrl.sv
// Player/enemy HP registers with a 1-HP-per-frame damage drain FSM and shared bar lookup.
// Optional heal requests are enabled by defining HP_HEAL_EN.
module hp_drain_ctrl
    import hp_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             new_battle,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_target,
    input  logic [HP_W-1:0]  req_amount,
`ifdef HP_HEAL_EN
    input  logic             req_heal,
`endif
    output logic [HP_W-1:0]  lookup_hp,
    input  logic [BAR_W-1:0] lookup_bar,
    output logic [HP_W-1:0]  player_hp,
    output logic [HP_W-1:0]  enemy_hp,
    output logic [BAR_W-1:0] player_bar,
    output logic [BAR_W-1:0] enemy_bar,
    output logic             player_faint,
    output logic             enemy_faint,
    output logic             drain_done,
    output drain_state_t     dbg_state
);

    localparam logic [HP_W-1:0] HP_ONE = 8'd1;

    drain_state_t    state, state_nxt;
    target_t         tgt_q, tgt_nxt;
    logic [HP_W-1:0] rem_q, rem_nxt;
    logic            heal_q, heal_nxt;
    logic            heal_in;
    logic [HP_W-1:0] player_hp_nxt, enemy_hp_nxt;
    logic [HP_W-1:0] req_hp, cur_hp, step_hp, end_hp;

`ifdef HP_HEAL_EN
    assign heal_in = req_heal;
`else
    assign heal_in = 1'b0;
`endif

    // Handshake: a request transfers on a cycle where req_valid && req_ready; req_ready is high only in IDLE.
    assign req_ready  = (state == IDLE);
    assign drain_done = (state == DONE);
    assign dbg_state  = state;

    assign req_hp  = req_target ? enemy_hp : player_hp;
    assign cur_hp  = (tgt_q == TGT_ENEMY) ? enemy_hp : player_hp;
    assign step_hp = heal_q ? (cur_hp + HP_ONE) : (cur_hp - HP_ONE);
    assign end_hp  = heal_q ? HP_MAX : '0;

    always_comb begin
        state_nxt     = state;
        tgt_nxt       = tgt_q;
        rem_nxt       = rem_q;
        heal_nxt      = heal_q;
        player_hp_nxt = player_hp;
        enemy_hp_nxt  = enemy_hp;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    tgt_nxt  = target_t'(req_target);
                    rem_nxt  = req_amount;
                    heal_nxt = heal_in;
                    // Nothing to move: zero amount, damage on a fainted target, heal on a full one.
                    if ((req_amount == '0) ||
                        (!heal_in && (req_hp == '0)) ||
                        (heal_in && (req_hp == HP_MAX)))
                        state_nxt = DONE;
                    else
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_tick) begin
                    rem_nxt = rem_q - HP_ONE;
                    if (tgt_q == TGT_ENEMY) enemy_hp_nxt  = step_hp;
                    else                    player_hp_nxt = step_hp;
                    if ((rem_q == HP_ONE) || (step_hp == end_hp))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                rem_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
        if (new_battle) begin
            state_nxt     = IDLE;
            rem_nxt       = '0;
            player_hp_nxt = HP_MAX;
            enemy_hp_nxt  = HP_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tgt_q     <= TGT_PLAYER;
            rem_q     <= '0;
            heal_q    <= 1'b0;
            player_hp <= HP_MAX;
            enemy_hp  <= HP_MAX;
        end else begin
            state     <= state_nxt;
            tgt_q     <= tgt_nxt;
            rem_q     <= rem_nxt;
            heal_q    <= heal_nxt;
            player_hp <= player_hp_nxt;
            enemy_hp  <= enemy_hp_nxt;
        end
    end

    // Faint flags trail HP by one cycle, except new_battle clears them immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            player_faint <= 1'b0;
            enemy_faint  <= 1'b0;
        end else if (new_battle) begin
            player_faint <= 1'b0;
            enemy_faint  <= 1'b0;
        end else begin
            player_faint <= (player_hp == '0);
            enemy_faint  <= (enemy_hp == '0);
        end
    end

    hp_bar_scheduler u_bar_sched (
        .clk        (clk),
        .reset_n    (reset_n),
        .player_hp  (player_hp),
        .enemy_hp   (enemy_hp),
        .lookup_hp  (lookup_hp),
        .lookup_bar (lookup_bar),
        .player_bar (player_bar),
        .enemy_bar  (enemy_bar)
    );

endmodule
